// File: rtl/btn_pkg.sv
// -----------------------------------------------------------------------------
// btn_pkg
// Shared definitions for the button press classifier:
//   - estado_t        : 2-bit classifier state (REPOSO / PRESIONADO / SOSTENIDO)
//   - *_DEF constants : default hold and repeat lengths for a 50 MHz clock
//   - max_u/cnt_width : helpers that size the shared hold/repeat counter
// -----------------------------------------------------------------------------
package btn_pkg;

    // Encoding 2'd3 is unused; the classifier treats it as a fault and
    // recovers to REPOSO.
    typedef enum logic [1:0] {
        REPOSO     = 2'd0,
        PRESIONADO = 2'd1,
        SOSTENIDO  = 2'd2
    } estado_t;

    // 3 s long-press threshold and 0.5 s auto-repeat period at 50 MHz.
    localparam int unsigned COUNT_LARGO_DEF   = 32'd150_000_000;
    localparam int unsigned COUNT_REPETIR_DEF = 32'd25_000_000;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        if (a > b) begin
            return a;
        end else begin
            return b;
        end
    endfunction

    // One counter serves both the long-press and the repeat phases, so it is
    // sized for the larger of the two thresholds (never narrower than 1 bit).
    function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b);
        int unsigned w;
        w = $clog2(max_u(a, b));
        if (w < 32'd1) begin
            return 32'd1;
        end else begin
            return w;
        end
    endfunction

endpackage

// File: rtl/btn_clasificador_chk.sv
// -----------------------------------------------------------------------------
// btn_clasificador_chk
// Simulation-only checker for btn_clasificador.
//   - parameters : COUNT_LARGO, COUNT_REPETIR (must both be >= 2)
//   - clk, reset : clock and active-low asynchronous reset of the classifier
//   - pulso_*    : the three classifier event outputs
// -----------------------------------------------------------------------------
module btn_clasificador_chk #(
    parameter int unsigned COUNT_LARGO   = 32'd2,
    parameter int unsigned COUNT_REPETIR = 32'd2
) (
    input logic clk,
    input logic reset,
    input logic pulso_corto,
    input logic pulso_largo,
    input logic pulso_repetir
);

    // Parameter ranges and mutual exclusion of the event pulses.
    always @(posedge clk) begin
        if (reset) begin
            assert (COUNT_LARGO >= 32'd2)
                else $error("btn_clasificador: COUNT_LARGO must be >= 2");
            assert (COUNT_REPETIR >= 32'd2)
                else $error("btn_clasificador: COUNT_REPETIR must be >= 2");
            assert ($onehot0({pulso_corto, pulso_largo, pulso_repetir}))
                else $error("btn_clasificador: event pulses overlap");
        end
    end

endmodule

// File: rtl/btn_clasificador.sv
// -----------------------------------------------------------------------------
// btn_clasificador
// Turns a debounced button level into single-cycle event pulses.
//   Parameters:
//     COUNT_LARGO   : hold length (cycles) that makes a long press, >= 2
//     COUNT_REPETIR : auto-repeat period (cycles) after a long press, >= 2
//     REPETIR_EN    : 1 = emit auto-repeat pulses, 0 = suppress them
//   Ports:
//     clk           : system clock (posedge)
//     reset         : asynchronous active-low reset
//     boton_in      : debounced button level, 1 = pressed, already in clk domain
//     pulso_corto   : 1-cycle pulse, press released before the long threshold
//     pulso_largo   : 1-cycle pulse, hold reached COUNT_LARGO
//     pulso_repetir : 1-cycle pulse every COUNT_REPETIR cycles after pulso_largo
//     presionado    : level, high while a press is being tracked
// -----------------------------------------------------------------------------
module btn_clasificador
    import btn_pkg::*;
#(
    parameter int unsigned COUNT_LARGO   = COUNT_LARGO_DEF,
    parameter int unsigned COUNT_REPETIR = COUNT_REPETIR_DEF,
    parameter bit          REPETIR_EN    = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic boton_in,
    output logic pulso_corto,
    output logic pulso_largo,
    output logic pulso_repetir,
    output logic presionado
);

    localparam int unsigned        CNT_W       = cnt_width(COUNT_LARGO, COUNT_REPETIR);
    localparam logic [CNT_W-1:0]   LARGO_FIN   = CNT_W'(COUNT_LARGO - 32'd1);
    localparam logic [CNT_W-1:0]   REPETIR_FIN = CNT_W'(COUNT_REPETIR - 32'd1);
    localparam logic [CNT_W-1:0]   CNT_CERO    = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0]   CNT_UNO     = {{(CNT_W-1){1'b0}}, 1'b1};

    estado_t          state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             boton_prev_q;
    logic             pulso_corto_q, pulso_corto_d;
    logic             pulso_largo_q, pulso_largo_d;
    logic             pulso_repetir_q, pulso_repetir_d;
    logic             presionado_q, presionado_d;
    logic             flanco_subida_s;

    // A press only starts on a fresh 0->1 edge; boton_prev resets to 1 so a
    // button held through reset release is ignored until it is seen at 0.
    assign flanco_subida_s = boton_in & ~boton_prev_q;

    // Next-state, counter and event-pulse decode.
    always_comb begin
        state_d         = state_q;
        cnt_d           = cnt_q;
        pulso_corto_d   = 1'b0;
        pulso_largo_d   = 1'b0;
        pulso_repetir_d = 1'b0;

        case (state_q)
            REPOSO: begin
                cnt_d = CNT_CERO;
                if (flanco_subida_s) begin
                    state_d = PRESIONADO;
                end else begin
                    state_d = REPOSO;
                end
            end

            PRESIONADO: begin
                // Release is tested first so it wins over the long threshold.
                if (!boton_in) begin
                    pulso_corto_d = 1'b1;
                    state_d       = REPOSO;
                    cnt_d         = CNT_CERO;
                end else if (cnt_q == LARGO_FIN) begin
                    pulso_largo_d = 1'b1;
                    state_d       = SOSTENIDO;
                    cnt_d         = CNT_CERO;
                end else begin
                    state_d = PRESIONADO;
                    cnt_d   = cnt_q + CNT_UNO;
                end
            end

            SOSTENIDO: begin
                if (!boton_in) begin
                    state_d = REPOSO;
                    cnt_d   = CNT_CERO;
                end else if (!REPETIR_EN) begin
                    state_d = SOSTENIDO;
                    cnt_d   = CNT_CERO;
                end else if (cnt_q == REPETIR_FIN) begin
                    pulso_repetir_d = 1'b1;
                    state_d         = SOSTENIDO;
                    cnt_d           = CNT_CERO;
                end else begin
                    state_d = SOSTENIDO;
                    cnt_d   = cnt_q + CNT_UNO;
                end
            end

            default: begin
                // Unused encoding: return to idle silently.
                state_d = REPOSO;
                cnt_d   = CNT_CERO;
            end
        endcase

        // Registered from the next state so it tracks state without extra lag.
        presionado_d = (state_d != REPOSO);
    end

    // State, counter, input history and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q         <= REPOSO;
            cnt_q           <= CNT_CERO;
            boton_prev_q    <= 1'b1;
            pulso_corto_q   <= 1'b0;
            pulso_largo_q   <= 1'b0;
            pulso_repetir_q <= 1'b0;
            presionado_q    <= 1'b0;
        end else begin
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            boton_prev_q    <= boton_in;
            pulso_corto_q   <= pulso_corto_d;
            pulso_largo_q   <= pulso_largo_d;
            pulso_repetir_q <= pulso_repetir_d;
            presionado_q    <= presionado_d;
        end
    end

    assign pulso_corto   = pulso_corto_q;
    assign pulso_largo   = pulso_largo_q;
    assign pulso_repetir = pulso_repetir_q;
    assign presionado    = presionado_q;

`ifndef SYNTHESIS
    btn_clasificador_chk #(
        .COUNT_LARGO   (COUNT_LARGO),
        .COUNT_REPETIR (COUNT_REPETIR)
    ) u_chk (
        .clk           (clk),
        .reset         (reset),
        .pulso_corto   (pulso_corto_q),
        .pulso_largo   (pulso_largo_q),
        .pulso_repetir (pulso_repetir_q)
    );
`endif

endmodule

// File: tb/tb_btn_clasificador.sv
// -----------------------------------------------------------------------------
// tb_btn_clasificador
// Two classifiers (auto-repeat on / off) share clock, reset and button input.
// Expected pulses come from a press-age model: a press accepted at edge t has
// age a = (edge - t); release at a <= L gives a short pulse, a == L while held
// gives the long pulse, and a = L + k*R gives the k-th repeat pulse.
// -----------------------------------------------------------------------------
module tb_btn_clasificador;

    localparam int L = 20;
    localparam int R = 5;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic boton_in = 1'b0;
    logic a_corto, a_largo, a_rep, a_pres;
    logic b_corto, b_largo, b_rep, b_pres;

    btn_clasificador #(.COUNT_LARGO(L), .COUNT_REPETIR(R), .REPETIR_EN(1'b1)) dut_a (
        .clk(clk), .reset(reset), .boton_in(boton_in),
        .pulso_corto(a_corto), .pulso_largo(a_largo),
        .pulso_repetir(a_rep), .presionado(a_pres)
    );

    btn_clasificador #(.COUNT_LARGO(L), .COUNT_REPETIR(R), .REPETIR_EN(1'b0)) dut_b (
        .clk(clk), .reset(reset), .boton_in(boton_in),
        .pulso_corto(b_corto), .pulso_largo(b_largo),
        .pulso_repetir(b_rep), .presionado(b_pres)
    );

    always #5 clk = ~clk;

    int n_total  = 0;
    int n_passed = 0;

    // reference model state
    bit m_act, m_prev;
    int m_age;
    bit e_corto, e_largo, e_rep, e_pres;

    // bookkeeping for timing-offset checks
    int cyc = 0;
    int rise_cyc = 0;
    bit pres_prev = 1'b0;
    int largo_offs[$];
    int rep_offs[$];
    int n_corto, n_largo, n_rep_b;

    typedef struct packed {
        logic b;
        logic pres;
        logic corto;
        logic largo;
        logic rep;
    } vec_t;
    vec_t tabla [9];

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end else begin
            n_passed++;
        end
    endtask

    task automatic model_reset();
        m_act = 1'b0; m_prev = 1'b1; m_age = 0;
        e_corto = 1'b0; e_largo = 1'b0; e_rep = 1'b0; e_pres = 1'b0;
    endtask

    task automatic model_edge(input bit b);
        e_corto = 1'b0; e_largo = 1'b0; e_rep = 1'b0;
        if (!m_act) begin
            if (b && !m_prev) begin
                m_act = 1'b1;
                m_age = 0;
            end
        end else begin
            m_age++;
            if (!b) begin
                if (m_age <= L) e_corto = 1'b1;
                m_act = 1'b0;
            end else if (m_age == L) begin
                e_largo = 1'b1;
            end else if (m_age > L && ((m_age - L) % R) == 0) begin
                e_rep = 1'b1;
            end
        end
        m_prev = b;
        e_pres = m_act;
    endtask

    task automatic clear_counts();
        largo_offs.delete();
        rep_offs.delete();
        n_corto = 0; n_largo = 0; n_rep_b = 0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_a_out"}, int'({a_corto, a_largo, a_rep, a_pres}), 0);
        chk({tag, "_b_out"}, int'({b_corto, b_largo, b_rep, b_pres}), 0);
    endtask

    // One clock: drive, let the edge happen, compare both DUTs 1 time unit later.
    task automatic step(input bit b);
        boton_in = b;
        @(posedge clk);
        if (!reset) model_reset();
        else model_edge(b);
        #1;
        chk("a_corto", int'(a_corto), int'(e_corto));
        chk("a_largo", int'(a_largo), int'(e_largo));
        chk("a_rep",   int'(a_rep),   int'(e_rep));
        chk("a_pres",  int'(a_pres),  int'(e_pres));
        chk("b_corto", int'(b_corto), int'(e_corto));
        chk("b_largo", int'(b_largo), int'(e_largo));
        chk("b_rep",   int'(b_rep),   0);
        chk("b_pres",  int'(b_pres),  int'(e_pres));
        if (a_pres && !pres_prev) rise_cyc = cyc;
        if (a_largo) begin largo_offs.push_back(cyc - rise_cyc); n_largo++; end
        if (a_rep) rep_offs.push_back(cyc - rise_cyc);
        if (a_corto) n_corto++;
        if (b_rep) n_rep_b++;
        pres_prev = a_pres;
        cyc++;
    endtask

    task automatic steps(input bit b, input int n);
        for (int i = 0; i < n; i++) step(b);
    endtask

    // Assert reset between edges and check outputs clear without a clock edge.
    task automatic async_reset(input string tag);
        #2;
        reset = 1'b0;
        #1;
        model_reset();
        chk_all_zero(tag);
    endtask

    initial begin
        model_reset();
        // expected press behaviour from idle (prev = 0)
        tabla[0] = '{b: 1'b0, pres: 1'b0, corto: 1'b0, largo: 1'b0, rep: 1'b0};
        tabla[1] = '{b: 1'b1, pres: 1'b1, corto: 1'b0, largo: 1'b0, rep: 1'b0};
        tabla[2] = '{b: 1'b1, pres: 1'b1, corto: 1'b0, largo: 1'b0, rep: 1'b0};
        tabla[3] = '{b: 1'b1, pres: 1'b1, corto: 1'b0, largo: 1'b0, rep: 1'b0};
        tabla[4] = '{b: 1'b0, pres: 1'b0, corto: 1'b1, largo: 1'b0, rep: 1'b0};
        tabla[5] = '{b: 1'b0, pres: 1'b0, corto: 1'b0, largo: 1'b0, rep: 1'b0};
        tabla[6] = '{b: 1'b1, pres: 1'b1, corto: 1'b0, largo: 1'b0, rep: 1'b0};
        tabla[7] = '{b: 1'b0, pres: 1'b0, corto: 1'b1, largo: 1'b0, rep: 1'b0};
        tabla[8] = '{b: 1'b0, pres: 1'b0, corto: 1'b0, largo: 1'b0, rep: 1'b0};

        // reset held with the button toggling: nothing moves
        for (int i = 0; i < 6; i++) step(i[0]);
        boton_in = 1'b0;
        #2 reset = 1'b1;
        steps(1'b0, 3);
        chk_all_zero("post_reset");

        // table-driven short presses (including a 1-cycle press)
        for (int i = 0; i < 9; i++) begin
            step(tabla[i].b);
            chk($sformatf("tbl%0d_pres", i),  int'(a_pres),  int'(tabla[i].pres));
            chk($sformatf("tbl%0d_corto", i), int'(a_corto), int'(tabla[i].corto));
            chk($sformatf("tbl%0d_largo", i), int'(a_largo), int'(tabla[i].largo));
            chk($sformatf("tbl%0d_rep", i),   int'(a_rep),   int'(tabla[i].rep));
        end

        // press 5 cycles then release
        clear_counts();
        steps(1'b1, 5);
        steps(1'b0, 3);
        chk("p5_corto_n", n_corto, 1);
        chk("p5_largo_n", n_largo, 0);

        // hold long enough for the long pulse and four repeats
        clear_counts();
        steps(1'b1, 41);
        steps(1'b0, 4);
        chk("hold_largo_n", largo_offs.size(), 1);
        if (largo_offs.size() == 1) chk("hold_largo_off", largo_offs[0], 20);
        chk("hold_rep_n", rep_offs.size(), 4);
        for (int k = 0; k < rep_offs.size() && k < 4; k++)
            chk($sformatf("hold_rep%0d_off", k), rep_offs[k], 25 + 5 * k);
        chk("hold_corto_n", n_corto, 0);
        chk("hold_b_rep_n", n_rep_b, 0);

        // release exactly on the long-threshold edge: short wins
        clear_counts();
        steps(1'b1, 20);
        steps(1'b0, 3);
        chk("edge19_corto_n", n_corto, 1);
        chk("edge19_largo_n", n_largo, 0);

        // button held through reset release is ignored until seen low
        clear_counts();
        async_reset("rst_held");
        boton_in = 1'b1;
        steps(1'b1, 2);
        reset = 1'b1;
        steps(1'b1, 30);
        chk("held_events", n_corto + n_largo + rep_offs.size(), 0);
        steps(1'b0, 2);
        steps(1'b1, 3);
        steps(1'b0, 2);
        chk("held_then_corto_n", n_corto, 1);

        // reset during SOSTENIDO clears outputs immediately, no pulse afterwards
        steps(1'b1, 25);
        async_reset("rst_sost");
        clear_counts();
        steps(1'b1, 3);
        reset = 1'b1;
        steps(1'b1, 5);
        steps(1'b0, 3);
        chk("rst_sost_events", n_corto + n_largo + rep_offs.size(), 0);

        // randomized runs against the model, with occasional mid-run resets
        for (int r = 0; r < 80; r++) begin
            int len;
            len = int'($urandom_range(1, 45));
            steps(r[0] ? 1'b0 : 1'b1, len);
            if ($urandom_range(0, 15) == 0) begin
                async_reset("rnd_rst");
                steps(1'($urandom_range(0, 1)), 2);
                reset = 1'b1;
            end
        end

        $display("%0d/%0d checks passed", n_passed, n_total);
        $finish;
    end

endmodule
